reg_bank_writer: RTL

Write side of the single-cycle RV32I integer register file. Decodes a 5-bit destination index into 32 write enables and holds the 32 architectural registers. Exposes all register contents as a flat bus that feeds the 32:1 read-select muxes. Adds a bulk-initialisation sequencer that walks all 32 registers, one per cycle, so the debug/boot logic can clear or preset the register file.

---
 rtl/reg_bank_writer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/reg_bank_writer.sv
// reg_bank_writer: write side of the RV32I integer register file.
//   Holds 32 architectural registers, decodes the write-back index into
//   per-register enables, and runs a bulk-initialisation sequencer that
//   writes one register per cycle (IDLE -> INIT x32 -> DONE -> IDLE).
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   write_enable/_address/_data  write-back request (accepted only in IDLE)
//   write_ready         high when a write request is accepted this cycle
//   init_start/init_value        bulk-initialisation request and fill value
//   init_busy           high while the sequencer walks the registers
//   init_done           single-cycle completion pulse
//   reg_values          flat registered contents, reg k at [k*WIDTH +: WIDTH]
// Optional macro REGBANK_WRITE_TRACE_EN adds last_write_address,
//   last_write_data and a saturating write_count for accepted writes.
module reg_bank_writer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [4:0]            write_address,
  input  logic [WIDTH-1:0]      write_data,
  output logic                  write_ready,
  input  logic                  init_start,
  input  logic [WIDTH-1:0]      init_value,
  output logic                  init_busy,
  output logic                  init_done,
`ifdef REGBANK_WRITE_TRACE_EN
  output logic [4:0]            last_write_address,
  output logic [WIDTH-1:0]      last_write_data,
  output logic [15:0]           write_count,
`endif
  output logic [32*WIDTH-1:0]   reg_values
);

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  fill_q, fill_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  regs_q [NREGS];
  logic [NREGS-1:0]  reg_we;
  logic [WIDTH-1:0]  reg_wdata;

  logic              zero_reg_en;
  assign zero_reg_en = (ZERO_REG != 0);

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, write decode and next status outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    reg_we    = '0;
    reg_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (write_enable) begin
          // x0 stays zero when hardwired; other registers take the write.
          if (!(zero_reg_en && (write_address == AW'(0)))) begin
            reg_we[write_address] = 1'b1;
          end
          reg_wdata = write_data;
        end
        if (init_start) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          fill_d  = init_value;
        end
      end
      ST_INIT: begin
        reg_we[cnt_q] = 1'b1;
        reg_wdata     = (zero_reg_en && (cnt_q == AW'(0))) ? '0 : fill_q;
        cnt_d         = AW'(cnt_q + AW'(1));
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_INIT);
    done_d  = (state_d == ST_DONE);
  end

  // Register array; at most one enable is set per cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(NREGS); k++) begin
      if (reset) begin
        regs_q[k] <= '0;
      end else if (reg_we[k]) begin
        regs_q[k] <= reg_wdata;
      end
    end
  end

  for (genvar g = 0; g < int'(NREGS); g++) begin : g_flat
    assign reg_values[g*WIDTH +: WIDTH] = regs_q[g];
  end

  assign write_ready = ready_q;
  assign init_busy   = busy_q;
  assign init_done   = done_q;

`ifdef REGBANK_WRITE_TRACE_EN
  logic [AW-1:0]    last_addr_q;
  logic [WIDTH-1:0] last_data_q;
  logic [15:0]      count_q;
  logic             accepted;

  // Accepted writes include suppressed writes to a hardwired x0.
  assign accepted = (state_q == ST_IDLE) && write_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr_q <= '0;
      last_data_q <= '0;
      count_q     <= '0;
    end else if (accepted) begin
      last_addr_q <= write_address;
      last_data_q <= write_data;
      if (count_q != 16'hFFFF) begin
        count_q <= 16'(count_q + 16'd1);
      end
    end
  end

  assign last_write_address = last_addr_q;
  assign last_write_data    = last_data_q;
  assign write_count        = count_q;
`endif

endmodule
